ip_prefetch_line: RTL

- Parametrised successor to the instruction-pointer line.
- Fetches opcodes from a synchronous instruction ROM into a prefetch FIFO and presents them to the execution line over a Ready/Ack handshake.
- Resolves Brainfuck-style loop brackets internally: forward skip on '[' with zero data, backward jump on ']' with non-zero data.
- Sits between instruction ROM and the AP/data-line sequencer.

---
 rtl/dpc_isa_pkg.sv | 28 ++
 rtl/ip_prefetch_fifo.sv | 78 +++++++
 rtl/ip_prefetch_line.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpc_isa_pkg.sv
// Shared ISA definitions for the data-pointer core: opcode encoding and the
// prefetch-line state encoding.
package dpc_isa_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    NOP        = 4'd0,
    INC        = 4'd1,
    DEC        = 4'd2,
    RIGHT      = 4'd3,
    LEFT       = 4'd4,
    OUT        = 4'd5,
    IN         = 4'd6,
    LOOP_BEGIN = 4'd7,
    LOOP_END   = 4'd8,
    HALT       = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_SEEK_FWD  = 3'd1,
    ST_SEEK_BACK = 3'd2,
    ST_HALTED    = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

endpackage

// File: rtl/ip_prefetch_fifo.sv
// Prefetch FIFO holding opcode + fetch address pairs, with a single-cycle
// flush that empties it regardless of push/pop.
module ip_prefetch_fifo
  import dpc_isa_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int IP_W  = 12,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [OP_W-1:0]  push_op,
  input  logic [IP_W-1:0]  push_ip,
  input  logic             pop,
  output logic [OP_W-1:0]  head_op,
  output logic [IP_W-1:0]  head_ip,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [OP_W-1:0]  op_q [DEPTH];
  logic [OP_W-1:0]  op_d [DEPTH];
  logic [IP_W-1:0]  ip_q [DEPTH];
  logic [IP_W-1:0]  ip_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    op_d     = op_q;
    ip_d     = ip_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        op_d[wr_ptr_q] = push_op;
        ip_d[wr_ptr_q] = push_ip;
        wr_ptr_d       = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    op_q <= op_d;
    ip_q <= ip_d;
  end

  assign head_op = op_q[rd_ptr_q];
  assign head_ip = ip_q[rd_ptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);

endmodule

// File: rtl/ip_prefetch_line.sv
// Instruction-pointer prefetch line: ROM fetch into a FIFO, Ready/Ack head
// handshake, internal bracket seeking. Optional macro LOOP_STACK_EN adds a
// loop-return stack that replaces the backward scan.
module ip_prefetch_line
  import dpc_isa_pkg::*;
#(
  parameter int IP_W        = 12,
  parameter int FIFO_DEPTH  = 4,
  parameter int NEST_W      = 8,
  parameter int STACK_DEPTH = 16,
  parameter int START_IP    = 0
) (
  input  logic            Clk,
  input  logic            Rst,
  output logic [IP_W-1:0] RomAddr,
  output logic            RomRd,
  input  logic [3:0]      RomData,
  input  logic            DataZero,
  output logic [3:0]      Opcode,
  output logic [IP_W-1:0] OpcodeIp,
  output logic            OpcodeReady,
  input  logic            OpcodeAck,
  output logic            Busy,
  output logic            Halted,
  output logic            Fault,
  output state_e          DbgState
);

  // Handshake: the head entry transfers on a Clk edge where OpcodeReady and
  // OpcodeAck are both 1; Opcode/OpcodeIp hold while Ready=1 and Ack=0.

  localparam int              CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IP_W-1:0] IP_MAX     = '1;
  localparam logic [NEST_W-1:0] NEST_MAX = '1;
  localparam logic [CNT_W:0]  FILL_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

  state_e            state_q, state_d;
  logic [IP_W-1:0]   ip_q, ip_d;
  logic [NEST_W-1:0] nest_q, nest_d;
  logic              rd_pend_q, rd_pend_d;
  logic [IP_W-1:0]   pend_ip_q, pend_ip_d;
  logic              flush_q, flush_d;
  logic              halt_seen_q, halt_seen_d;
  logic              wrap_q, wrap_d;

  logic              fifo_flush, fifo_push, fifo_pop, fifo_empty;
  logic [OP_W-1:0]   head_op;
  logic [IP_W-1:0]   head_ip;
  logic [CNT_W-1:0]  fifo_count;

  logic              rom_rd, head_ready, accept, fetch_room, halt_queued;
  logic              clear_req, fault_req, seek_done, seek_fwd;
  logic [OP_W-1:0]   seek_open, seek_close;

  ip_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .IP_W  (IP_W)
  ) u_fifo (
    .clk     (Clk),
    .rst     (Rst),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .push_op (RomData),
    .push_ip (pend_ip_q),
    .pop     (fifo_pop),
    .head_op (head_op),
    .head_ip (head_ip),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

`ifdef LOOP_STACK_EN
  localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [IP_W-1:0] stack_q [STACK_DEPTH];
  logic [IP_W-1:0] stack_d [STACK_DEPTH];
  logic [SP_W:0]   sp_q, sp_d;
  logic [SP_W-1:0] top_idx;
  logic            stack_push;

  assign top_idx = sp_q[SP_W-1:0] - 1'b1;

  always_comb begin
    stack_d = stack_q;
    if (stack_push) begin
      stack_d[sp_q[SP_W-1:0]] = head_ip;
    end
  end

  always_ff @(posedge Clk) begin
    stack_q <= stack_d;
  end

  always_ff @(posedge Clk) begin
    if (Rst) sp_q <= '0;
    else     sp_q <= sp_d;
  end
`endif

  assign head_ready  = (state_q == ST_FETCH) && !fifo_empty;
  assign accept      = head_ready && OpcodeAck;
  assign fetch_room  = ((CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(rd_pend_q)) < FILL_LIMIT;
  // A HALT already fetched (or arriving now) stops further ROM reads.
  assign halt_queued = halt_seen_q || (rd_pend_q && (RomData == HALT));
  assign seek_fwd    = (state_q == ST_SEEK_FWD);
  assign seek_open   = seek_fwd ? LOOP_BEGIN : LOOP_END;
  assign seek_close  = seek_fwd ? LOOP_END : LOOP_BEGIN;

  always_comb begin
    state_d     = state_q;
    ip_d        = ip_q;
    nest_d      = nest_q;
    rd_pend_d   = 1'b0;
    pend_ip_d   = pend_ip_q;
    flush_d     = 1'b0;
    halt_seen_d = halt_seen_q;
    wrap_d      = wrap_q;
    rom_rd      = 1'b0;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    clear_req   = 1'b0;
    fault_req   = 1'b0;
    seek_done   = 1'b0;
`ifdef LOOP_STACK_EN
    sp_d        = sp_q;
    stack_push  = 1'b0;
`endif
    case (state_q)
      ST_FETCH: begin
        fifo_push = rd_pend_q;
        if (rd_pend_q && (RomData == HALT)) halt_seen_d = 1'b1;
        if (fetch_room && !halt_queued) begin
          rom_rd    = 1'b1;
          rd_pend_d = 1'b1;
          pend_ip_d = ip_q;
          ip_d      = ip_q + 1'b1;
        end
        if (accept) begin
          fifo_pop = 1'b1;
          case (head_op)
            LOOP_BEGIN: begin
              if (DataZero) begin
                if (head_ip == IP_MAX) begin
                  fault_req = 1'b1;
                end else begin
                  clear_req = 1'b1;
                  flush_d   = 1'b1;
                  nest_d    = NEST_W'(1);
                  ip_d      = head_ip + 1'b1;
                  state_d   = ST_SEEK_FWD;
                end
              end else begin
`ifdef LOOP_STACK_EN
                if (sp_q == (SP_W + 1)'(STACK_DEPTH)) begin
                  fault_req = 1'b1;
                end else begin
                  stack_push = 1'b1;
                  sp_d       = sp_q + 1'b1;
                end
`endif
              end
            end
            LOOP_END: begin
              if (!DataZero) begin
`ifdef LOOP_STACK_EN
                if (sp_q == '0) begin
                  fault_req = 1'b1;
                end else begin
                  clear_req = 1'b1;
                  flush_d   = 1'b1;
                  ip_d      = stack_q[top_idx] + 1'b1;
                end
`else
                if (head_ip == '0) begin
                  fault_req = 1'b1;
                end else begin
                  clear_req = 1'b1;
                  flush_d   = 1'b1;
                  nest_d    = NEST_W'(1);
                  ip_d      = head_ip - 1'b1;
                  state_d   = ST_SEEK_BACK;
                end
`endif
              end else begin
`ifdef LOOP_STACK_EN
                if (sp_q == '0) fault_req = 1'b1;
                else            sp_d      = sp_q - 1'b1;
`endif
              end
            end
            HALT: begin
              clear_req = 1'b1;
              state_d   = ST_HALTED;
            end
            default: ;
          endcase
        end
      end
      ST_SEEK_FWD, ST_SEEK_BACK: begin
        if (rd_pend_q) begin
          if (RomData == seek_open) begin
            if (nest_q == NEST_MAX) fault_req = 1'b1;
            else                    nest_d    = nest_q + 1'b1;
          end else if (RomData == seek_close) begin
            nest_d = nest_q - 1'b1;
            if (nest_q == NEST_W'(1)) begin
              seek_done = 1'b1;
              wrap_d    = 1'b0;
              ip_d      = pend_ip_q + 1'b1;
              state_d   = ST_FETCH;
            end
          end
        end
        // wrap_q means the last in-range address was already issued.
        if (!seek_done && !fault_req) begin
          if (wrap_q) begin
            fault_req = 1'b1;
          end else begin
            rom_rd    = 1'b1;
            rd_pend_d = 1'b1;
            pend_ip_d = ip_q;
            if (seek_fwd) begin
              ip_d   = ip_q + 1'b1;
              wrap_d = (ip_q == IP_MAX);
            end else begin
              ip_d   = ip_q - 1'b1;
              wrap_d = (ip_q == '0);
            end
          end
        end
      end
      ST_HALTED: ;
      ST_FAULT:  ;
      default:   fault_req = 1'b1;
    endcase

    if (clear_req || fault_req) begin
      fifo_flush  = 1'b1;
      fifo_push   = 1'b0;
      rd_pend_d   = 1'b0;
      halt_seen_d = 1'b0;
      wrap_d      = 1'b0;
    end
    if (fault_req) begin
      flush_d = 1'b0;
      state_d = ST_FAULT;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_FETCH;
      ip_q        <= IP_W'(START_IP);
      nest_q      <= '0;
      rd_pend_q   <= 1'b0;
      pend_ip_q   <= '0;
      flush_q     <= 1'b0;
      halt_seen_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ip_q        <= ip_d;
      nest_q      <= nest_d;
      rd_pend_q   <= rd_pend_d;
      pend_ip_q   <= pend_ip_d;
      flush_q     <= flush_d;
      halt_seen_q <= halt_seen_d;
      wrap_q      <= wrap_d;
    end
  end

  assign RomAddr     = ip_q;
  assign RomRd       = rom_rd && !Rst;
  assign OpcodeReady = head_ready;
  assign Opcode      = head_ready ? head_op : '0;
  assign OpcodeIp    = head_ready ? head_ip : '0;
  assign Busy        = flush_q || (state_q == ST_SEEK_FWD) || (state_q == ST_SEEK_BACK);
  assign Halted      = (state_q == ST_HALTED);
  assign Fault       = (state_q == ST_FAULT);
  assign DbgState    = state_q;

endmodule
